// File: rtl/decoder_sweep_pkg.sv
// Shared state encoding and golden truth-table constants for the decoder sweep sequencer.
package decoder_sweep_pkg;

  localparam int unsigned NUM_VEC = 32;

  // Golden F of (AB' + A'B)(C + D'); bit i is ABCD = i.
  localparam logic [15:0] GOLD_EN0_DEF = 16'h0000;
  localparam logic [15:0] GOLD_EN1_DEF = 16'h0DD0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/sweep_checker.sv
// Compares each sampled F against the golden table and keeps the result word,
// the mismatch count and the first failing vector index.
module sweep_checker
  import decoder_sweep_pkg::*;
#(
  parameter logic [15:0] GOLD_EN0 = GOLD_EN0_DEF,
  parameter logic [15:0] GOLD_EN1 = GOLD_EN1_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        sample_en,
  input  logic [4:0]  vec,
  input  logic        f_i,
  output logic [31:0] result,
  output logic [5:0]  mismatch_cnt,
  output logic [4:0]  first_fail_idx,
  output logic        fail_valid
);

  // Indexed by {en, abcd}, matching the layout of result.
  localparam logic [31:0] GOLD = {GOLD_EN1, GOLD_EN0};

  logic miss;
  assign miss = sample_en && (f_i != GOLD[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result         <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      fail_valid     <= 1'b0;
    end else if (clear) begin
      result         <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      fail_valid     <= 1'b0;
    end else if (sample_en) begin
      result[vec] <= f_i;
      if (miss) begin
        mismatch_cnt <= mismatch_cnt + 6'd1;
        if (!fail_valid) begin
          first_fail_idx <= vec;
          fail_valid     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/decoder_sweep_ctrl.sv
// Sweeps en/ABCD through all 32 vectors of the decoder-based F unit, samples F after a
// programmable settle time and reports the truth table against golden masks.
module decoder_sweep_ctrl
  import decoder_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,  // legal range 1..15
  parameter logic [15:0] GOLD_EN0   = GOLD_EN0_DEF,
  parameter logic [15:0] GOLD_EN1   = GOLD_EN1_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_i,
  output logic        en_o,
  output logic [3:0]  abcd_o,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        aborted,
  output logic [31:0] result,
  output logic [5:0]  mismatch_cnt,
  output logic [4:0]  first_fail_idx,
  output logic        fail_valid,
  output logic [2:0]  state_dbg
);

  // Handshake: start is honoured only in IDLE (abort in the same cycle wins); busy is
  // high through DRIVE/SETTLE/SAMPLE; done pulses for the single DONE cycle, after
  // which every status output holds until the next accepted start.

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [4:0] LAST_VEC    = 5'(NUM_VEC - 1);

  sweep_state_t state_q, state_d;
  logic [4:0]   vec_q, vec_d;
  logic [3:0]   settle_q, settle_d;
  logic [4:0]   drive_q, drive_d;
  logic         pass_q, pass_d;
  logic         aborted_q, aborted_d;
  logic         clear;
  logic         sample_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      settle_q  <= '0;
      drive_q   <= '0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
      drive_q   <= drive_d;
      pass_q    <= pass_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    drive_d   = drive_q;
    pass_d    = pass_q;
    aborted_d = aborted_q;
    clear     = 1'b0;
    sample_en = 1'b0;

    case (state_q)
      IDLE: begin
        drive_d = '0;
        if (start && !abort) begin
          clear     = 1'b1;
          vec_d     = '0;
          pass_d    = 1'b0;
          aborted_d = 1'b0;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == 4'd0) state_d = SAMPLE;
        else                  settle_d = settle_q - 4'd1;
      end
      SAMPLE: begin
        sample_en = 1'b1;
        if (vec_q == LAST_VEC) begin
          drive_d = '0;
          state_d = DONE;
        end else begin
          // The next vector is registered now so it is already on the pins during DRIVE.
          vec_d   = vec_q + 5'd1;
          drive_d = vec_q + 5'd1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        // mismatch_cnt already holds the last SAMPLE update by this cycle.
        pass_d  = (mismatch_cnt == 6'd0) && !aborted_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides the active states; a SAMPLE cut short records nothing.
    if (abort && (state_q == DRIVE || state_q == SETTLE || state_q == SAMPLE)) begin
      sample_en = 1'b0;
      vec_d     = vec_q;
      drive_d   = '0;
      aborted_d = 1'b1;
      pass_d    = 1'b0;
      state_d   = DONE;
    end
  end

  sweep_checker #(
    .GOLD_EN0 (GOLD_EN0),
    .GOLD_EN1 (GOLD_EN1)
  ) u_checker (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .sample_en      (sample_en),
    .vec            (vec_q),
    .f_i            (f_i),
    .result         (result),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_idx (first_fail_idx),
    .fail_valid     (fail_valid)
  );

  assign {en_o, abcd_o} = drive_q;
  assign busy      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign aborted   = aborted_q;
  assign state_dbg = state_q;

endmodule
